vme_slave_responder: RTL and testbench

VMEbus slave (responder) for the card's local resources: watches the backplane for A24 cycles that hit this board's window and forwards each one as a single local-bus transaction. It then drives DTACK* and the data transceivers back to the remote master. It sits beside the initiator-side transfer logic and shares the backplane buffers with it. It only responds while the local initiator does not own the bus.

---
 rtl/vme_slave_responder_pkg.sv | 47 ++++
 rtl/vme_slave_responder_sync.sv | 27 ++
 rtl/vme_slave_responder.sv | 170 +++++++++++++++++
 tb/tb_vme_slave_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_slave_responder_pkg.sv
// Shared VMEbus definitions: strobe levels, transceiver direction, A24 AM codes,
// slave state encoding and byte-lane helpers.
package vme_slave_responder_pkg;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam logic [5:0] AM_A24_USR_DATA = 6'h39;
  localparam logic [5:0] AM_A24_USR_PROG = 6'h3A;
  localparam logic [5:0] AM_A24_SUP_DATA = 6'h3D;
  localparam logic [5:0] AM_A24_SUP_PROG = 6'h3E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACCESS,
    ST_ACK,
    ST_WAIT_RELEASE
  } vme_state_e;

  function automatic logic am_is_a24(input logic [5:0] am);
    return (am == AM_A24_USR_DATA) || (am == AM_A24_USR_PROG) ||
           (am == AM_A24_SUP_DATA) || (am == AM_A24_SUP_PROG);
  endfunction

  // Big-endian lanes: be[3] is byte offset 0.
  function automatic logic [3:0] byte_enables(input logic lword_n,
                                              input logic [1:0] ds_n,
                                              input logic a1);
    logic [3:0] be;
    if (ds_n == 2'b00)
      be = (lword_n == ACTIVE) ? 4'b1111 : (a1 ? 4'b0011 : 4'b1100);
    else
      be = 4'b1000 >> {a1, ~ds_n[0]};
    return be;
  endfunction

  function automatic logic size_illegal(input logic lword_n,
                                        input logic [1:0] ds_n,
                                        input logic a1);
    return (lword_n == ACTIVE) && (a1 || (ds_n != 2'b00));
  endfunction

endpackage

// File: rtl/vme_slave_responder_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous backplane strobes.
module vme_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vme_slave_responder.sv
// VMEbus A24 slave: forwards backplane cycles hitting BASE to the local bus and drives DTACK.
// Optional VME_SLAVE_BERR_EN adds BERR on illegal size and a local_ack timeout.
module vme_slave_responder
  import vme_slave_responder_pkg::*;
#(
  parameter logic [3:0] BASE = 4'h3
`ifdef VME_SLAVE_BERR_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_bus_owned,
  input  logic        i_vme_as,
  input  logic [1:0]  i_vme_ds,
  input  logic        i_vme_lword,
  input  logic        i_vme_write,
  input  logic [23:0] i_vme_address,
  input  logic [5:0]  i_vme_address_mod,
  output logic        o_vme_dtack,
  output logic        o_vme_berr,
  output logic        o_data_oe,
  output logic        o_data_dir,
  output logic        o_local_req,
  output logic        o_local_write,
  output logic [23:0] o_local_addr,
  output logic [3:0]  o_local_be,
  input  logic        i_local_ack
);

  logic [3:0] w_sync_q;
  logic       w_as_s;
  logic [1:0] w_ds_s;
  logic       w_write_s;
  logic       w_sel;
  logic       w_illegal;
  logic [3:0] w_be;
  logic       w_unused_addr0;

  vme_state_e  r_state;
  logic        r_dtack;
  logic        r_data_oe;
  logic        r_data_dir;
  logic        r_local_req;
  logic        r_local_write;
  logic [23:0] r_local_addr;
  logic [3:0]  r_local_be;

  vme_sync #(.W(4), .RST_VAL(4'hF)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     ({i_vme_as, i_vme_ds, i_vme_write}),
    .o_q     (w_sync_q)
  );

  assign w_as_s    = w_sync_q[3];
  assign w_ds_s    = w_sync_q[2:1];
  assign w_write_s = w_sync_q[0];

  // Address, AM and LWORD are stable while AS is low, so they are used raw.
  assign w_sel     = (i_bus_owned == INACTIVE) && am_is_a24(i_vme_address_mod) &&
                     (i_vme_address[23:20] == BASE);
  assign w_be      = byte_enables(i_vme_lword, w_ds_s, i_vme_address[1]);
  assign w_illegal = size_illegal(i_vme_lword, w_ds_s, i_vme_address[1]);
  assign w_unused_addr0 = i_vme_address[0];

`ifdef VME_SLAVE_BERR_EN
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic             r_berr;
  logic [TMO_W-1:0] r_tmo;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_dtack       <= INACTIVE;
      r_data_oe     <= INACTIVE;
      r_data_dir    <= DIR_IN;
      r_local_req   <= 1'b0;
      r_local_write <= 1'b0;
      r_local_addr  <= '0;
      r_local_be    <= '0;
`ifdef VME_SLAVE_BERR_EN
      r_berr        <= INACTIVE;
      r_tmo         <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_as_s == ACTIVE) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (w_as_s == INACTIVE) begin
            r_state <= ST_IDLE;
          end else if (!w_sel) begin
            r_state <= ST_WAIT_RELEASE;
          end else if (w_ds_s != 2'b11) begin
            if (w_illegal) begin
`ifdef VME_SLAVE_BERR_EN
              r_berr  <= ACTIVE;
              r_state <= ST_ACK;
`else
              r_state <= ST_WAIT_RELEASE;
`endif
            end else begin
              r_local_req   <= 1'b1;
              r_local_write <= (w_write_s == ACTIVE);
              r_local_addr  <= {i_vme_address[23:2], 2'b00};
              r_local_be    <= w_be;
              r_data_dir    <= (w_write_s == ACTIVE) ? DIR_IN : DIR_OUT;
              r_data_oe     <= ACTIVE;
              r_state       <= ST_ACCESS;
`ifdef VME_SLAVE_BERR_EN
              r_tmo         <= '0;
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (w_as_s == INACTIVE) begin
            r_local_req <= 1'b0;
            r_data_oe   <= INACTIVE;
            r_state     <= ST_IDLE;
          end else if (i_local_ack) begin
            r_local_req <= 1'b0;
            r_dtack     <= ACTIVE;
            r_state     <= ST_ACK;
`ifdef VME_SLAVE_BERR_EN
          end else if (r_tmo == TMO_LAST) begin
            r_local_req <= 1'b0;
            r_berr      <= ACTIVE;
            r_state     <= ST_ACK;
          end else begin
            r_tmo <= r_tmo + 1'b1;
`endif
          end
        end
        ST_ACK: begin
          if (w_ds_s == 2'b11) begin
            r_dtack   <= INACTIVE;
            r_data_oe <= INACTIVE;
`ifdef VME_SLAVE_BERR_EN
            r_berr    <= INACTIVE;
`endif
            r_state   <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (w_as_s == INACTIVE) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_vme_dtack   = r_dtack;
  assign o_data_oe     = r_data_oe;
  assign o_data_dir    = r_data_dir;
  assign o_local_req   = r_local_req;
  assign o_local_write = r_local_write;
  assign o_local_addr  = r_local_addr;
  assign o_local_be    = r_local_be;
`ifdef VME_SLAVE_BERR_EN
  assign o_vme_berr    = r_berr;
`else
  assign o_vme_berr    = INACTIVE;
`endif

endmodule

// File: tb/tb_vme_slave_responder.sv
// Directed bench for vme_slave_responder; BERR scenarios compile in with VME_SLAVE_BERR_EN.
module tb_vme_slave_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_owned;
  logic        as_n;
  logic [1:0]  ds_n;
  logic        lword_n;
  logic        write_n;
  logic [23:0] addr;
  logic [5:0]  am;
  logic        dtack, berr, oe, dir, req, lwr;
  logic [23:0] laddr;
  logic [3:0]  be;
  logic        ack;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vme_slave_responder dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_bus_owned       (bus_owned),
    .i_vme_as          (as_n),
    .i_vme_ds          (ds_n),
    .i_vme_lword       (lword_n),
    .i_vme_write       (write_n),
    .i_vme_address     (addr),
    .i_vme_address_mod (am),
    .o_vme_dtack       (dtack),
    .o_vme_berr        (berr),
    .o_data_oe         (oe),
    .o_data_dir        (dir),
    .o_local_req       (req),
    .o_local_write     (lwr),
    .o_local_addr      (laddr),
    .o_local_be        (be),
    .i_local_ack       (ack)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    as_n = 1'b1; ds_n = 2'b11; lword_n = 1'b1; write_n = 1'b1;
    addr = '0; am = '0; ack = 1'b0; bus_owned = 1'b1;
  endtask

  task automatic begin_addr(input logic [23:0] a, input logic [5:0] m,
                            input logic lw, input logic wr);
    addr = a; am = m; lword_n = lw; write_n = wr; as_n = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    total++; if ({dtack, berr, oe} !== 3'b111) $display("FAIL reset_strobes got %b want 111", {dtack, berr, oe}); else passed++;
    total++; if ({dir, req, lwr} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {dir, req, lwr}); else passed++;
    total++; if ({laddr, be} !== 28'h0) $display("FAIL reset_addr_be got %h/%b want 0/0", laddr, be); else passed++;
  endtask

  task automatic test_read_lword();
    begin_addr(24'h300010, 6'h3D, 1'b0, 1'b1);
    ds_n = 2'b00;
    tick(2);
    total++; if (req !== 1'b0) $display("FAIL rd_req_early got %b want 0", req); else passed++;
    tick(1);
    total++; if (req !== 1'b1) $display("FAIL rd_req_latency got %b want 1", req); else passed++;
    total++; if (laddr !== 24'h300010) $display("FAIL rd_addr got %h want 300010", laddr); else passed++;
    total++; if (be !== 4'b1111) $display("FAIL rd_be got %b want 1111", be); else passed++;
    total++; if ({lwr, dir, oe, dtack} !== 4'b0101) $display("FAIL rd_ctrl got %b want 0101", {lwr, dir, oe, dtack}); else passed++;
    tick(3);
    total++; if (req !== 1'b1) $display("FAIL rd_req_hold got %b want 1", req); else passed++;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    total++; if ({dtack, req, oe, dir} !== 4'b0001) $display("FAIL rd_dtack got %b want 0001", {dtack, req, oe, dir}); else passed++;
    ds_n = 2'b11;
    tick(2);
    total++; if (dtack !== 1'b0) $display("FAIL rd_dtack_held got %b want 0", dtack); else passed++;
    tick(1);
    total++; if ({dtack, oe} !== 2'b11) $display("FAIL rd_release got %b want 11", {dtack, oe}); else passed++;
    as_n = 1'b1;
    tick(4);
  endtask

  task automatic test_byte_write();
    begin_addr(24'h300102, 6'h39, 1'b1, 1'b0);
    ds_n = 2'b10;
    tick(3);
    total++; if (req !== 1'b1) $display("FAIL bw_req got %b want 1", req); else passed++;
    total++; if (be !== 4'b0001) $display("FAIL bw_be got %b want 0001", be); else passed++;
    total++; if (laddr !== 24'h300100) $display("FAIL bw_addr got %h want 300100", laddr); else passed++;
    total++; if ({lwr, dir, oe} !== 3'b100) $display("FAIL bw_ctrl got %b want 100", {lwr, dir, oe}); else passed++;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    total++; if (dtack !== 1'b0) $display("FAIL bw_dtack got %b want 0", dtack); else passed++;
    ds_n = 2'b11;
    tick(3);
    total++; if (dtack !== 1'b1) $display("FAIL bw_release got %b want 1", dtack); else passed++;
    as_n = 1'b1;
    tick(4);
  endtask

  task automatic test_lanes();
    logic [23:0] ta [5] = '{24'h300006, 24'h300000, 24'h300000, 24'h300002, 24'h300002};
    logic [1:0]  td [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
    logic [3:0]  tb [5] = '{4'b0011, 4'b1100, 4'b1000, 4'b0001, 4'b0010};
    logic [23:0] tl [5] = '{24'h300004, 24'h300000, 24'h300000, 24'h300000, 24'h300000};
    for (int i = 0; i < 5; i++) begin
      begin_addr(ta[i], 6'h3A, 1'b1, 1'b1);
      ds_n = td[i];
      tick(3);
      total++; if ({req, be} !== {1'b1, tb[i]}) $display("FAIL lane%0d_be got %b/%b want 1/%b", i, req, be, tb[i]); else passed++;
      total++; if (laddr !== tl[i]) $display("FAIL lane%0d_addr got %h want %h", i, laddr, tl[i]); else passed++;
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      ds_n = 2'b11;
      tick(3);
      as_n = 1'b1;
      tick(4);
    end
  endtask

  task automatic test_miss();
    logic [23:0] ma [3] = '{24'h400000, 24'h300010, 24'h300010};
    logic [5:0]  mm [3] = '{6'h3D, 6'h29, 6'h3D};
    logic        mo [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      logic seen = 1'b0;
      bus_owned = mo[i];
      begin_addr(ma[i], mm[i], 1'b0, 1'b1);
      ds_n = 2'b00;
      repeat (8) begin
        tick(1);
        if (req || !dtack || !oe) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) $display("FAIL miss%0d_quiet got activity=%b want 0", i, seen); else passed++;
      ds_n = 2'b11;
      as_n = 1'b1;
      tick(4);
      bus_owned = 1'b1;
    end
  endtask

  task automatic test_abort();
    int  drop_at = 0;
    logic saw_dt = 1'b0;
    begin_addr(24'h300020, 6'h39, 1'b1, 1'b1);
    ds_n = 2'b00;
    tick(3);
    total++; if (req !== 1'b1) $display("FAIL ab_req got %b want 1", req); else passed++;
    as_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      if (!dtack) saw_dt = 1'b1;
      if (!req && drop_at == 0) drop_at = k;
    end
    total++; if (drop_at != 3) $display("FAIL ab_req_drop got clk %0d want 3", drop_at); else passed++;
    total++; if ({saw_dt, oe} !== 2'b01) $display("FAIL ab_no_dtack got %b want 01", {saw_dt, oe}); else passed++;
    ds_n = 2'b11;
    tick(3);
    begin_addr(24'h300030, 6'h3E, 1'b1, 1'b1);
    ds_n = 2'b01;
    tick(3);
    total++; if ({req, be} !== 5'b11000) $display("FAIL ab_next_cycle got %b want 11000", {req, be}); else passed++;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    total++; if (dtack !== 1'b0) $display("FAIL ab_next_dtack got %b want 0", dtack); else passed++;
    ds_n = 2'b11;
    tick(3);
    as_n = 1'b1;
    tick(4);
  endtask

  task automatic test_illegal();
    logic saw_req = 1'b0, saw_dt = 1'b0, saw_berr = 1'b0;
    begin_addr(24'h300012, 6'h3D, 1'b0, 1'b1);
    ds_n = 2'b00;
    repeat (6) begin
      tick(1);
      if (req) saw_req = 1'b1;
      if (!dtack) saw_dt = 1'b1;
      if (!berr) saw_berr = 1'b1;
    end
    total++; if ({saw_req, saw_dt} !== 2'b00) $display("FAIL il_no_req_dtack got %b want 00", {saw_req, saw_dt}); else passed++;
`ifdef VME_SLAVE_BERR_EN
    total++; if (saw_berr !== 1'b1) $display("FAIL il_berr got %b want 1", saw_berr); else passed++;
    ds_n = 2'b11;
    tick(3);
    total++; if (berr !== 1'b1) $display("FAIL il_berr_release got %b want 1", berr); else passed++;
`else
    total++; if (saw_berr !== 1'b0) $display("FAIL il_berr_held got %b want 0", saw_berr); else passed++;
    ds_n = 2'b11;
    tick(3);
`endif
    as_n = 1'b1;
    tick(4);
  endtask

`ifdef VME_SLAVE_BERR_EN
  task automatic test_timeout();
    begin_addr(24'h300040, 6'h3D, 1'b0, 1'b1);
    ds_n = 2'b00;
    tick(3);
    total++; if (req !== 1'b1) $display("FAIL to_req got %b want 1", req); else passed++;
    tick(63);
    total++; if ({berr, req} !== 2'b11) $display("FAIL to_early got %b want 11", {berr, req}); else passed++;
    tick(1);
    total++; if ({berr, req, dtack} !== 3'b001) $display("FAIL to_berr got %b want 001", {berr, req, dtack}); else passed++;
    ds_n = 2'b11;
    tick(3);
    total++; if ({berr, oe} !== 2'b11) $display("FAIL to_release got %b want 11", {berr, oe}); else passed++;
    as_n = 1'b1;
    tick(4);
  endtask
`endif

  task automatic test_reset_mid_ack();
    begin_addr(24'h300010, 6'h3D, 1'b0, 1'b1);
    ds_n = 2'b00;
    tick(3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    total++; if ({dtack, oe} !== 2'b00) $display("FAIL rma_in_ack got %b want 00", {dtack, oe}); else passed++;
    rst = 1'b1;
    tick(1);
    total++; if ({dtack, oe, req} !== 3'b110) $display("FAIL rma_release got %b want 110", {dtack, oe, req}); else passed++;
    bus_idle();
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    test_reset();
    test_read_lword();
    test_byte_write();
    test_lanes();
    test_miss();
    test_abort();
    test_illegal();
`ifdef VME_SLAVE_BERR_EN
    test_timeout();
`endif
    test_reset_mid_ack();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
